// File: rtl/tl_ram_responder.sv
// rtl/tl_ram_responder.sv - TileLink-UH RAM responder, one transaction in flight
//
// Purpose: terminates a TileLink-UH A/D channel pair (64-bit data, 6-bit source,
// 32-bit address) and serves Get / PutFull / PutPartial from an internal word RAM.
// Arith/Logic requests are answered as denied; Hint gets a HintAck.
//
// Optional feature macro: TL_RESP_DENY_EN
//   defined   : addresses outside [BASE, BASE+8*DEPTH) are refused (denied=1)
//   undefined : no range check, upper address bits alias onto the RAM
//
// Ports:
//   clock, reset_n              clock and asynchronous active-low reset
//   auto_in_a_*                 A channel (request) from the requester
//   auto_in_d_*                 D channel (response) to the requester
module tl_ram_responder #(
  parameter int unsigned DEPTH = 512,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [5:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [5:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_HINT        = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_PUT, S_GET, S_ACK} state_t;

  state_t r_state;
  state_t w_next;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_idx;
  logic [3:0]    r_cnt;
  // Set for a refused transaction: suppresses RAM access on all later beats.
  logic          r_deny;

  logic [2:0]  r_d_opcode;
  logic [2:0]  r_d_size;
  logic [5:0]  r_d_source;
  logic        r_d_denied;
  logic        r_d_corrupt;
  logic [63:0] r_d_data;

  logic          w_a_fire;
  logic          w_d_fire;
  logic [AW-1:0] w_a_idx;
  logic [AW-1:0] w_idx_inc;
  logic [3:0]    w_beats_m1;
  logic          w_is_put;
  logic          w_is_get;
  logic          w_is_hint;
  logic          w_in_range;
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic          w_unused;

  assign auto_in_a_ready = (r_state == S_IDLE) || (r_state == S_PUT);
  assign auto_in_d_valid = (r_state == S_GET) || (r_state == S_ACK);

  assign w_a_fire  = auto_in_a_valid && auto_in_a_ready;
  assign w_d_fire  = auto_in_d_valid && auto_in_d_ready;
  assign w_a_idx   = auto_in_a_bits_address[3+AW-1:3];
  assign w_idx_inc = r_idx + IDX_ONE;

  assign w_is_put  = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                     (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
  assign w_is_get  = (auto_in_a_bits_opcode == OP_GET);
  assign w_is_hint = (auto_in_a_bits_opcode == OP_HINT);

  // Remaining beats after the first one.
  always_comb begin
    w_beats_m1 = 4'd0;
    case (auto_in_a_bits_size)
      3'd4:    w_beats_m1 = 4'd1;
      3'd5:    w_beats_m1 = 4'd3;
      3'd6:    w_beats_m1 = 4'd7;
      3'd7:    w_beats_m1 = 4'd15;
      default: w_beats_m1 = 4'd0;
    endcase
  end

`ifdef TL_RESP_DENY_EN
  localparam logic [31:0] SPAN = 32'(8 * DEPTH);
  logic [32:0] w_off;
  // Offset underflows (bit 32 set) when the address lies below BASE.
  assign w_off      = {1'b0, auto_in_a_bits_address} - {1'b0, BASE};
  assign w_in_range = !w_off[32] && (w_off[31:0] < SPAN);
  assign w_unused   = ^{auto_in_a_bits_param, w_off[32]};
`else
  assign w_in_range = 1'b1;
  assign w_unused   = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0],
                        auto_in_a_bits_address[31:3+AW], BASE};
`endif

  // Corrupt beats are skipped; a zero mask naturally writes nothing.
  always_comb begin
    w_we   = 1'b0;
    w_widx = w_a_idx;
    if (r_state == S_IDLE) begin
      w_we   = w_a_fire && w_is_put && w_in_range && !auto_in_a_bits_corrupt;
      w_widx = w_a_idx;
    end else if (r_state == S_PUT) begin
      w_we   = w_a_fire && !r_deny && !auto_in_a_bits_corrupt;
      w_widx = w_idx_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (auto_in_a_bits_mask[b]) begin
          r_mem[w_widx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_a_fire) begin
          if (w_is_put) begin
            w_next = (w_beats_m1 == 4'd0) ? S_ACK : S_PUT;
          end else if (w_is_hint) begin
            w_next = S_ACK;
          end else begin
            w_next = S_GET;
          end
        end
      end
      // r_cnt counts beats still to come; the beat that sees 1 is the last.
      S_PUT: begin
        if (w_a_fire && (r_cnt == 4'd1)) begin
          w_next = S_ACK;
        end
      end
      S_GET: begin
        if (w_d_fire && (r_cnt == 4'd0)) begin
          w_next = S_IDLE;
        end
      end
      S_ACK: begin
        if (w_d_fire) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Response data is captured into r_d_data when the read is issued, so a
  // stalled beat holds stable and the next beat is ready one cycle after fire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_cnt       <= 4'd0;
      r_deny      <= 1'b0;
      r_d_opcode  <= 3'd0;
      r_d_size    <= 3'd0;
      r_d_source  <= 6'd0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_a_fire) begin
            r_idx      <= w_a_idx;
            r_cnt      <= w_beats_m1;
            r_d_size   <= auto_in_a_bits_size;
            r_d_source <= auto_in_a_bits_source;
            r_d_data   <= 64'd0;
            if (w_is_put) begin
              r_d_opcode  <= D_ACCESS_ACK;
              r_deny      <= !w_in_range;
              r_d_denied  <= !w_in_range;
              r_d_corrupt <= 1'b0;
            end else if (w_is_get) begin
              r_d_opcode  <= D_ACCESS_ACK_DATA;
              r_deny      <= !w_in_range;
              r_d_denied  <= !w_in_range;
              r_d_corrupt <= !w_in_range;
              if (w_in_range) begin
                r_d_data <= r_mem[w_a_idx];
              end
            end else if (w_is_hint) begin
              r_d_opcode  <= D_HINT_ACK;
              r_deny      <= 1'b0;
              r_d_denied  <= 1'b0;
              r_d_corrupt <= 1'b0;
            end else begin
              r_d_opcode  <= D_ACCESS_ACK_DATA;
              r_deny      <= 1'b1;
              r_d_denied  <= 1'b1;
              r_d_corrupt <= 1'b1;
            end
          end
        end
        S_PUT: begin
          if (w_a_fire) begin
            r_idx <= w_idx_inc;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_GET: begin
          if (w_d_fire && (r_cnt != 4'd0)) begin
            r_idx <= w_idx_inc;
            r_cnt <= r_cnt - 4'd1;
            if (!r_deny) begin
              r_d_data <= r_mem[w_idx_inc];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign auto_in_d_bits_opcode  = r_d_opcode;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = r_d_size;
  assign auto_in_d_bits_source  = r_d_source;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = r_d_denied;
  assign auto_in_d_bits_data    = r_d_data;
  assign auto_in_d_bits_corrupt = r_d_corrupt;

endmodule

// File: tb/tb_tl_ram_responder.sv
// tb/tb_tl_ram_responder.sv - self-checking bench for tl_ram_responder
module tb_tl_ram_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        auto_in_a_ready;
  logic        auto_in_a_valid = 1'b0;
  logic [2:0]  auto_in_a_bits_opcode = 3'd0;
  logic [2:0]  auto_in_a_bits_param = 3'd0;
  logic [2:0]  auto_in_a_bits_size = 3'd0;
  logic [5:0]  auto_in_a_bits_source = 6'd0;
  logic [31:0] auto_in_a_bits_address = 32'd0;
  logic [7:0]  auto_in_a_bits_mask = 8'd0;
  logic [63:0] auto_in_a_bits_data = 64'd0;
  logic        auto_in_a_bits_corrupt = 1'b0;
  logic        auto_in_d_ready = 1'b0;
  logic        auto_in_d_valid;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [2:0]  auto_in_d_bits_size;
  logic [5:0]  auto_in_d_bits_source;
  logic        auto_in_d_bits_sink;
  logic        auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;

  int n_checks = 0;
  int n_fail = 0;

  tl_ram_responder #(.DEPTH(512), .BASE(32'h0)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .auto_in_a_ready(auto_in_a_ready),
    .auto_in_a_valid(auto_in_a_valid),
    .auto_in_a_bits_opcode(auto_in_a_bits_opcode),
    .auto_in_a_bits_param(auto_in_a_bits_param),
    .auto_in_a_bits_size(auto_in_a_bits_size),
    .auto_in_a_bits_source(auto_in_a_bits_source),
    .auto_in_a_bits_address(auto_in_a_bits_address),
    .auto_in_a_bits_mask(auto_in_a_bits_mask),
    .auto_in_a_bits_data(auto_in_a_bits_data),
    .auto_in_a_bits_corrupt(auto_in_a_bits_corrupt),
    .auto_in_d_ready(auto_in_d_ready),
    .auto_in_d_valid(auto_in_d_valid),
    .auto_in_d_bits_opcode(auto_in_d_bits_opcode),
    .auto_in_d_bits_param(auto_in_d_bits_param),
    .auto_in_d_bits_size(auto_in_d_bits_size),
    .auto_in_d_bits_source(auto_in_d_bits_source),
    .auto_in_d_bits_sink(auto_in_d_bits_sink),
    .auto_in_d_bits_denied(auto_in_d_bits_denied),
    .auto_in_d_bits_data(auto_in_d_bits_data),
    .auto_in_d_bits_corrupt(auto_in_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic [63:0] e_data;
    logic        e_den;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size,
                              input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data, input logic corrupt,
                              input logic [2:0] e_op, input logic [63:0] e_data,
                              input logic e_den);
    vec_t v;
    v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data;
    v.corrupt = corrupt; v.e_op = e_op; v.e_data = e_data; v.e_den = e_den;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the A beat fired.
  task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src,
                        input logic [31:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic corrupt);
    int n = 0;
    auto_in_a_valid        = 1'b1;
    auto_in_a_bits_opcode  = op;
    auto_in_a_bits_size    = size;
    auto_in_a_bits_source  = src;
    auto_in_a_bits_address = addr;
    auto_in_a_bits_mask    = mask;
    auto_in_a_bits_data    = data;
    auto_in_a_bits_corrupt = corrupt;
    while (!auto_in_a_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_ready_timeout: got 0 expected 1");
    end
    @(posedge clock); #1;
    auto_in_a_valid = 1'b0;
  endtask

  task automatic d_expect(input string nm, input logic [2:0] op, input logic [2:0] sz,
                          input logic [5:0] src, input logic [63:0] data,
                          input logic den, input logic cor);
    int n = 0;
    auto_in_d_ready = 1'b1;
    while (!auto_in_d_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, ".valid"}, 64'(auto_in_d_valid), 64'd1);
    chk({nm, ".opcode"}, 64'(auto_in_d_bits_opcode), 64'(op));
    chk({nm, ".size"}, 64'(auto_in_d_bits_size), 64'(sz));
    chk({nm, ".source"}, 64'(auto_in_d_bits_source), 64'(src));
    chk({nm, ".data"}, auto_in_d_bits_data, data);
    chk({nm, ".denied"}, 64'(auto_in_d_bits_denied), 64'(den));
    chk({nm, ".corrupt"}, 64'(auto_in_d_bits_corrupt), 64'(cor));
    chk({nm, ".param_sink"}, 64'({auto_in_d_bits_param, auto_in_d_bits_sink}), 64'd0);
    @(posedge clock); #1;
    auto_in_d_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] e13_data;
    logic        e13_den;
    int          guard;
    int          beat;
    logic        rdy;

`ifdef TL_RESP_DENY_EN
    e13_data = 64'd0;
    e13_den  = 1'b1;
`else
    e13_data = 64'h1111_2222_3333_4444;
    e13_den  = 1'b0;
`endif
    vecs[0]  = mk(3'd0, 3'd3, 32'h40,  8'hFF, 64'hDEADBEEF_01234567, 1'b0, 3'd0, 64'd0, 1'b0);
    vecs[1]  = mk(3'd4, 3'd3, 32'h40,  8'h00, 64'd0, 1'b0, 3'd1, 64'hDEADBEEF_01234567, 1'b0);
    vecs[2]  = mk(3'd1, 3'd3, 32'h40,  8'h0F, 64'hFFFFFFFF_AAAAAAAA, 1'b0, 3'd0, 64'd0, 1'b0);
    vecs[3]  = mk(3'd4, 3'd3, 32'h40,  8'h00, 64'd0, 1'b0, 3'd1, 64'hDEADBEEF_AAAAAAAA, 1'b0);
    vecs[4]  = mk(3'd0, 3'd3, 32'h40,  8'hFF, 64'h0, 1'b1, 3'd0, 64'd0, 1'b0);
    vecs[5]  = mk(3'd4, 3'd3, 32'h40,  8'h00, 64'd0, 1'b0, 3'd1, 64'hDEADBEEF_AAAAAAAA, 1'b0);
    vecs[6]  = mk(3'd0, 3'd3, 32'h40,  8'h00, 64'h0, 1'b0, 3'd0, 64'd0, 1'b0);
    vecs[7]  = mk(3'd4, 3'd3, 32'h40,  8'h00, 64'd0, 1'b0, 3'd1, 64'hDEADBEEF_AAAAAAAA, 1'b0);
    vecs[8]  = mk(3'd5, 3'd3, 32'h40,  8'h00, 64'd0, 1'b0, 3'd2, 64'd0, 1'b0);
    vecs[9]  = mk(3'd0, 3'd3, 32'h0,   8'hFF, 64'h1111_2222_3333_4444, 1'b0, 3'd0, 64'd0, 1'b0);
    vecs[10] = mk(3'd4, 3'd2, 32'h4,   8'h00, 64'd0, 1'b0, 3'd1, 64'h1111_2222_3333_4444, 1'b0);
    vecs[11] = mk(3'd0, 3'd3, 32'hFF8, 8'hFF, 64'h7777_6666_5555_4444, 1'b0, 3'd0, 64'd0, 1'b0);
    vecs[12] = mk(3'd4, 3'd3, 32'hFF8, 8'h00, 64'd0, 1'b0, 3'd1, 64'h7777_6666_5555_4444, 1'b0);
    vecs[13] = mk(3'd4, 3'd3, 32'h1000, 8'h00, 64'd0, 1'b0, 3'd1, e13_data, e13_den);

    // Reset state
    #12;
    chk("rst.d_valid", 64'(auto_in_d_valid), 64'd0);
    chk("rst.a_ready", 64'(auto_in_a_ready), 64'd1);
    chk("rst.d_bits", {auto_in_d_bits_data[31:0], 5'd0, auto_in_d_bits_opcode,
                       auto_in_d_bits_param, auto_in_d_bits_size, auto_in_d_bits_source,
                       auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_corrupt,
                       11'd0}, 64'd0);
    chk("rst.d_data", auto_in_d_bits_data, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single-beat table: response valid the cycle after A fires
    for (int i = 0; i < NV; i++) begin
      a_beat(vecs[i].op, vecs[i].size, 6'(i + 3), vecs[i].addr, vecs[i].mask,
             vecs[i].data, vecs[i].corrupt);
      chk($sformatf("vec%0d.latency", i), 64'(auto_in_d_valid), 64'd1);
      d_expect($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].size, 6'(i + 3),
               vecs[i].e_data, vecs[i].e_den,
               (vecs[i].e_op == 3'd1) ? vecs[i].e_den : 1'b0);
    end

    // 8-beat PutFull, no D until the last beat
    for (int i = 0; i < 8; i++) begin
      a_beat(3'd0, 3'd6, 6'd33, 32'h100, 8'hFF, 64'(i), 1'b0);
      if (i < 7) begin
        chk($sformatf("burst_put.no_d%0d", i), 64'(auto_in_d_valid), 64'd0);
        chk($sformatf("burst_put.a_ready%0d", i), 64'(auto_in_a_ready), 64'd1);
      end
    end
    d_expect("burst_put.ack", 3'd0, 3'd6, 6'd33, 64'd0, 1'b0, 1'b0);

    // 8-beat Get back-to-back
    auto_in_d_ready = 1'b1;
    a_beat(3'd4, 3'd6, 6'd34, 32'h100, 8'h00, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst_get.valid%0d", i), 64'(auto_in_d_valid), 64'd1);
      chk($sformatf("burst_get.data%0d", i), auto_in_d_bits_data, 64'(i));
      chk($sformatf("burst_get.size%0d", i), 64'(auto_in_d_bits_size), 64'd6);
      chk($sformatf("burst_get.op%0d", i), 64'(auto_in_d_bits_opcode), 64'd1);
      chk($sformatf("burst_get.a_ready%0d", i), 64'(auto_in_a_ready), 64'd0);
      @(posedge clock); #1;
    end
    auto_in_d_ready = 1'b0;
    chk("burst_get.done_valid", 64'(auto_in_d_valid), 64'd0);
    chk("burst_get.done_a_ready", 64'(auto_in_a_ready), 64'd1);

    // Get burst with random back-pressure
    a_beat(3'd4, 3'd6, 6'd35, 32'h100, 8'h00, 64'd0, 1'b0);
    beat = 0;
    guard = 0;
    while (beat < 8 && guard < 200) begin
      rdy = 1'($urandom_range(0, 1));
      auto_in_d_ready = rdy;
      chk($sformatf("stall.valid%0d", beat), 64'(auto_in_d_valid), 64'd1);
      chk($sformatf("stall.data%0d", beat), auto_in_d_bits_data, 64'(beat));
      chk($sformatf("stall.a_ready%0d", beat), 64'(auto_in_a_ready), 64'd0);
      @(posedge clock); #1;
      if (rdy) beat++;
      guard++;
    end
    auto_in_d_ready = 1'b0;
    chk("stall.beats", 64'(beat), 64'd8);
    chk("stall.done_valid", 64'(auto_in_d_valid), 64'd0);

    // Arith size 4: two denied data beats; Logic single beat
    a_beat(3'd2, 3'd4, 6'd40, 32'h40, 8'hFF, 64'h1234, 1'b0);
    d_expect("arith.b0", 3'd1, 3'd4, 6'd40, 64'd0, 1'b1, 1'b1);
    d_expect("arith.b1", 3'd1, 3'd4, 6'd40, 64'd0, 1'b1, 1'b1);
    chk("arith.done", 64'(auto_in_d_valid), 64'd0);
    a_beat(3'd3, 3'd3, 6'd41, 32'h40, 8'hFF, 64'h1234, 1'b0);
    d_expect("logic", 3'd1, 3'd3, 6'd41, 64'd0, 1'b1, 1'b1);
    a_beat(3'd4, 3'd3, 6'd42, 32'h40, 8'h00, 64'd0, 1'b0);
    d_expect("arith.no_write", 3'd1, 3'd3, 6'd42, 64'hDEADBEEF_AAAAAAAA, 1'b0, 1'b0);

    // Reset in the middle of a Get burst
    auto_in_d_ready = 1'b1;
    a_beat(3'd4, 3'd6, 6'd50, 32'h100, 8'h00, 64'd0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_mid.pre_valid", 64'(auto_in_d_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.d_valid", 64'(auto_in_d_valid), 64'd0);
    auto_in_d_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid.a_ready", 64'(auto_in_a_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_mid.quiet%0d", i), 64'(auto_in_d_valid), 64'd0);
      @(posedge clock); #1;
    end
    a_beat(3'd4, 3'd3, 6'd51, 32'h108, 8'h00, 64'd0, 1'b0);
    d_expect("rst_mid.ram_kept", 3'd1, 3'd3, 6'd51, 64'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
